// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and default timing constants for the pushbutton front end
//
// Contents:
//   btn_state_t            debouncer FSM state encoding
//   DEBOUNCE_COUNT_12MHZ   10 ms of stable input at 12 MHz
//   LONG_PRESS_COUNT_12MHZ 1 s of accepted press at 12 MHz
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int DEBOUNCE_COUNT_12MHZ   = 120000;
    localparam int LONG_PRESS_COUNT_12MHZ = 12000000;

endpackage

// File: rtl/bit_synchronizer.sv
// rtl/bit_synchronizer.sv - multi-flop synchronizer for a single asynchronous input pin
//
// Parameters:
//   STAGES  number of flip-flops in the chain (>= 2)
// Ports:
//   clk     destination clock
//   rst_n   synchronous active-low reset, clears every stage to 0
//   d       asynchronous input
//   q       synchronized output (last stage)
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stages;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[STAGES-2:0], d};
        end
    end

    assign q = stages[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - debounced, edge-detecting front end for an active-low pushbutton
//
// Optional feature macro: BUTTON_LONG_PRESS_EN (adds LONG_PRESS_COUNT and the long_press strobe)
// Parameters:
//   DEBOUNCE_COUNT    cycles of stable synchronized input before a press/release is accepted (>= 2)
//   LONG_PRESS_COUNT  cycles of accepted press before long_press fires (>= 2, macro builds only)
//   SYNC_STAGES       synchronizer depth (>= 2)
// Ports:
//   clk            system clock
//   rst_btn        synchronous active-low reset
//   btn            raw active-low pushbutton, asynchronous to clk
//   btn_level      debounced pressed level (1 = pressed)
//   press_pulse    one-cycle strobe per accepted press
//   release_pulse  one-cycle strobe per accepted release
//   long_press     one-cycle strobe, at most once per press (macro builds only)
module button_debouncer
    import button_pkg::*;
#(
    parameter int DEBOUNCE_COUNT   = DEBOUNCE_COUNT_12MHZ,
`ifdef BUTTON_LONG_PRESS_EN
    parameter int LONG_PRESS_COUNT = LONG_PRESS_COUNT_12MHZ,
`endif
    parameter int SYNC_STAGES      = 2
) (
    input  logic clk,
    input  logic rst_btn,
    input  logic btn,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
`ifdef BUTTON_LONG_PRESS_EN
    ,
    output logic long_press
`endif
);

    localparam int              DB_W    = $clog2(DEBOUNCE_COUNT);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_COUNT - 1);

    logic             pressed_raw;
    logic             sync;
    btn_state_t       state;
    btn_state_t       state_next;
    btn_state_t       prev_state;
    logic [DB_W-1:0]  db_cnt;
    logic             db_done;
    logic             level_d;
    logic             press_d;
    logic             release_d;

    // Invert at the pin so everything downstream is active-high "pressed".
    assign pressed_raw = ~btn;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_btn),
        .d     (pressed_raw),
        .q     (sync)
    );

    assign db_done = (db_cnt == DB_LAST);

    // State register. prev_state lets the output logic see which edge was
    // just taken, so the strobes stay Moore-style and fully registered.
    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            state      <= IDLE;
            prev_state <= IDLE;
            db_cnt     <= '0;
        end else begin
            state      <= state_next;
            prev_state <= state;
            if (state_next != state) begin
                db_cnt <= '0;
            end else if (state == PRESS_WAIT || state == RELEASE_WAIT) begin
                db_cnt <= db_cnt + DB_W'(1);
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (sync) state_next = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!sync)        state_next = IDLE;
                else if (db_done) state_next = PRESSED;
            end
            PRESSED: begin
                if (!sync) state_next = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (sync)         state_next = PRESSED;
                else if (db_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode. A return from RELEASE_WAIT to PRESSED is a bounce and
    // must not re-announce the press, hence the prev_state qualifier.
    always_comb begin
        level_d   = (state == PRESSED) || (state == RELEASE_WAIT);
        press_d   = (state == PRESSED) && (prev_state == PRESS_WAIT);
        release_d = (state == IDLE)    && (prev_state == RELEASE_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            btn_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam int              LP_W    = $clog2(LONG_PRESS_COUNT);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_COUNT - 1);

    logic [LP_W-1:0] hold_cnt;
    logic            long_fired;
    logic            long_hit;

    // long_fired blocks a second strobe while the saturated count is held,
    // including across release bounces that drop back into PRESSED.
    assign long_hit = (hold_cnt == LP_LAST) && !long_fired;

    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            hold_cnt   <= '0;
            long_fired <= 1'b0;
            long_press <= 1'b0;
        end else begin
            long_press <= long_hit;
            if (state == PRESS_WAIT && state_next == PRESSED) begin
                hold_cnt   <= '0;
                long_fired <= 1'b0;
            end else begin
                if (state == PRESSED && hold_cnt != LP_LAST) begin
                    hold_cnt <= hold_cnt + LP_W'(1);
                end
                if (long_hit) begin
                    long_fired <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - scoreboard bench for button_debouncer (DEBOUNCE_COUNT=4, LONG_PRESS_COUNT=20, SYNC_STAGES=2)
module tb_button_debouncer;

    localparam logic [1:0] K_PRESS   = 2'd0;
    localparam logic [1:0] K_RELEASE = 2'd1;
    localparam logic [1:0] K_LONG    = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_btn;
    logic btn;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
`ifdef BUTTON_LONG_PRESS_EN
    logic long_press;
`endif

    int unsigned cyc = 0;
    int n_cmp  = 0;
    int n_fail = 0;
    int both_high = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_debouncer #(
        .DEBOUNCE_COUNT   (4),
`ifdef BUTTON_LONG_PRESS_EN
        .LONG_PRESS_COUNT (20),
`endif
        .SYNC_STAGES      (2)
    ) dut (
        .clk           (clk),
        .rst_btn       (rst_btn),
        .btn           (btn),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
`ifdef BUTTON_LONG_PRESS_EN
        ,
        .long_press    (long_press)
`endif
    );

    // Monitor: every strobe becomes an observed event stamped with the edge count.
    always @(negedge clk) begin
        if (press_pulse === 1'b1)   obs_q.push_back(ev_t'{K_PRESS, cyc});
        if (release_pulse === 1'b1) obs_q.push_back(ev_t'{K_RELEASE, cyc});
`ifdef BUTTON_LONG_PRESS_EN
        if (long_press === 1'b1)    obs_q.push_back(ev_t'{K_LONG, cyc});
`endif
        if (press_pulse === 1'b1 && release_pulse === 1'b1) both_high++;
    end

    task automatic wait_to(input int unsigned n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic test_reset();
        ev_t o;
        rst_btn = 1'b0;
        btn     = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (btn_level !== 1'b0)     begin n_fail++; $display("FAIL reset btn_level got %b want 0", btn_level); end
        n_cmp++; if (press_pulse !== 1'b0)   begin n_fail++; $display("FAIL reset press_pulse got %b want 0", press_pulse); end
        n_cmp++; if (release_pulse !== 1'b0) begin n_fail++; $display("FAIL reset release_pulse got %b want 0", release_pulse); end
`ifdef BUTTON_LONG_PRESS_EN
        n_cmp++; if (long_press !== 1'b0)    begin n_fail++; $display("FAIL reset long_press got %b want 0", long_press); end
`endif
        rst_btn = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_fail++;
            o = obs_q[0];
            $display("FAIL reset_idle got %0d events (first kind=%0d cycle=%0d) want 0", obs_q.size(), o.kind, o.cyc);
            obs_q.delete();
        end
    endtask

    task automatic test_clean_press();
        ev_t e, o;
        int unsigned c;
        c = cyc;
        btn = 1'b0;
        exp_q.push_back(ev_t'{K_PRESS, c + 8});
        wait_to(c + 7);
        n_cmp++; if (btn_level !== 1'b0) begin n_fail++; $display("FAIL clean_press early btn_level got %b want 0", btn_level); end
        wait_to(c + 8);
        n_cmp++; if (btn_level !== 1'b1) begin n_fail++; $display("FAIL clean_press btn_level got %b want 1", btn_level); end
        wait_to(c + 13);
        n_cmp++; if (btn_level !== 1'b1 || press_pulse !== 1'b0) begin
            n_fail++; $display("FAIL clean_press hold level/pulse got %b/%b want 1/0", btn_level, press_pulse);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL clean_press event got none want kind=%0d cycle=%0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL clean_press event got kind=%0d cycle=%0d want kind=%0d cycle=%0d", o.kind, o.cyc, e.kind, e.cyc); end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            o = obs_q[0];
            n_fail++; $display("FAIL clean_press extra got %0d events (kind=%0d cycle=%0d) want 0", obs_q.size(), o.kind, o.cyc);
            obs_q.delete();
        end
    endtask

    task automatic test_release_bounce();
        ev_t e, o;
        int unsigned c;
        c = cyc;
        btn = 1'b1;
        wait_to(c + 3);
        btn = 1'b0;
        wait_to(c + 5);
        btn = 1'b1;
        exp_q.push_back(ev_t'{K_RELEASE, c + 13});
        wait_to(c + 12);
        n_cmp++; if (btn_level !== 1'b1) begin n_fail++; $display("FAIL release_bounce held level got %b want 1", btn_level); end
        wait_to(c + 13);
        n_cmp++; if (btn_level !== 1'b0) begin n_fail++; $display("FAIL release_bounce level got %b want 0", btn_level); end
        wait_to(c + 18);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL release_bounce event got none want kind=%0d cycle=%0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL release_bounce event got kind=%0d cycle=%0d want kind=%0d cycle=%0d", o.kind, o.cyc, e.kind, e.cyc); end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            o = obs_q[0];
            n_fail++; $display("FAIL release_bounce extra got %0d events (kind=%0d cycle=%0d) want 0", obs_q.size(), o.kind, o.cyc);
            obs_q.delete();
        end
    endtask

    task automatic test_bounce();
        ev_t o;
        for (int i = 0; i < 6; i++) begin
            btn = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) @(negedge clk);
            n_cmp++; if (btn_level !== 1'b0) begin n_fail++; $display("FAIL bounce level step %0d got %b want 0", i, btn_level); end
        end
        btn = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (btn_level !== 1'b0) begin n_fail++; $display("FAIL bounce final level got %b want 0", btn_level); end
        n_cmp++;
        if (obs_q.size() != 0) begin
            o = obs_q[0];
            n_fail++; $display("FAIL bounce events got %0d (kind=%0d cycle=%0d) want 0", obs_q.size(), o.kind, o.cyc);
            obs_q.delete();
        end
    endtask

    task automatic test_long_press();
        ev_t e, o;
        int unsigned c, c2;
        c = cyc;
        btn = 1'b0;
        exp_q.push_back(ev_t'{K_PRESS, c + 8});
`ifdef BUTTON_LONG_PRESS_EN
        exp_q.push_back(ev_t'{K_LONG, c + 8 + 19});
`endif
        wait_to(c + 8 + 40);
        c2 = cyc;
        btn = 1'b1;
        exp_q.push_back(ev_t'{K_RELEASE, c2 + 8});
        wait_to(c2 + 14);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL long_press event got none want kind=%0d cycle=%0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL long_press event got kind=%0d cycle=%0d want kind=%0d cycle=%0d", o.kind, o.cyc, e.kind, e.cyc); end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            o = obs_q[0];
            n_fail++; $display("FAIL long_press extra got %0d events (kind=%0d cycle=%0d) want 0", obs_q.size(), o.kind, o.cyc);
            obs_q.delete();
        end
    endtask

    // Shortest accepted press/release pairs: press strobes 2*(4+1) cycles apart.
    task automatic test_back_to_back();
        ev_t e, o;
        int unsigned c;
        c = cyc;
        btn = 1'b0;
        exp_q.push_back(ev_t'{K_PRESS, c + 8});
        exp_q.push_back(ev_t'{K_RELEASE, c + 13});
        exp_q.push_back(ev_t'{K_PRESS, c + 18});
        exp_q.push_back(ev_t'{K_RELEASE, c + 23});
        wait_to(c + 5);  btn = 1'b1;
        wait_to(c + 10); btn = 1'b0;
        wait_to(c + 15); btn = 1'b1;
        wait_to(c + 28);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL back_to_back event got none want kind=%0d cycle=%0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL back_to_back event got kind=%0d cycle=%0d want kind=%0d cycle=%0d", o.kind, o.cyc, e.kind, e.cyc); end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            o = obs_q[0];
            n_fail++; $display("FAIL back_to_back extra got %0d events (kind=%0d cycle=%0d) want 0", obs_q.size(), o.kind, o.cyc);
            obs_q.delete();
        end
        n_cmp++; if (both_high != 0) begin n_fail++; $display("FAIL pulse_overlap got %0d cycles want 0", both_high); end
    endtask

    task automatic test_reset_mid_press();
        ev_t e, o;
        int unsigned c, c2;
        c = cyc;
        btn = 1'b0;
        wait_to(c + 4);
        rst_btn = 1'b0;
        @(negedge clk);
        n_cmp++; if (btn_level !== 1'b0 || press_pulse !== 1'b0 || release_pulse !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid outputs got %b%b%b want 000", btn_level, press_pulse, release_pulse);
        end
        rst_btn = 1'b1;
        exp_q.push_back(ev_t'{K_PRESS, cyc + 8});
        wait_to(cyc + 12);
        n_cmp++; if (btn_level !== 1'b1) begin n_fail++; $display("FAIL reset_mid level got %b want 1", btn_level); end
        c2 = cyc;
        btn = 1'b1;
        exp_q.push_back(ev_t'{K_RELEASE, c2 + 8});
        wait_to(c2 + 12);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL reset_mid event got none want kind=%0d cycle=%0d", e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL reset_mid event got kind=%0d cycle=%0d want kind=%0d cycle=%0d", o.kind, o.cyc, e.kind, e.cyc); end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            o = obs_q[0];
            n_fail++; $display("FAIL reset_mid extra got %0d events (kind=%0d cycle=%0d) want 0", obs_q.size(), o.kind, o.cyc);
            obs_q.delete();
        end
    endtask

    initial begin
        rst_btn = 1'b0;
        btn     = 1'b1;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_release_bounce();
        test_bounce();
        test_long_press();
        test_back_to_back();
        test_reset_mid_press();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Debounced, edge-detecting front end for the board's active-low pushbuttons. It turns a raw, bouncing button input into a clean pressed level plus single-cycle press and release pulses. Those pulses are the `go` strobes the counting state machines consume. It sits between the pin and any FSM, in the same 12 MHz clock domain as the FSM it feeds. It replaces direct use of `~go_btn` in downstream logic.

## Interface
- `DEBOUNCE_COUNT`, 120000: cycles the synchronized input must stay stable before a press or release is accepted (10 ms at 12 MHz). Must be ≥ 2.
- `LONG_PRESS_COUNT`, 12000000: cycles of accepted press before `long_press` fires (1 s at 12 MHz). Must be ≥ 2.
- `SYNC_STAGES`, 2: flip-flops in the input synchronizer. Must be ≥ 2.
- `clk`  in  1  12 MHz system clock.
- `rst_btn`  in  1  reset. Synchronous, active-low.
- `btn`  in  1  raw pushbutton, active-low, asynchronous to `clk`.
- `btn_level`  out  1  debounced pressed level (1 = pressed).
- `press_pulse`  out  1  one-cycle strobe on each accepted press.
- `release_pulse`  out  1  one-cycle strobe on each accepted release.
- `long_press`  out  1  one-cycle strobe, at most once per press. Only present with `BUTTON_LONG_PRESS_EN`.

## Operation
- Input path: `~btn` feeds a `SYNC_STAGES`-deep synchronizer. Its last stage, `sync`, is the only signal the FSM sees. Reset loads all synchronizer stages with 0 (unpressed).
- Debounce counter width is `$clog2(DEBOUNCE_COUNT)`. It clears on every state change and increments while in a wait state.
- FSM states and transitions:
  - IDLE: `sync`=1 → PRESS_WAIT.
  - PRESS_WAIT: `sync`=0 → IDLE, with no output. `sync`=1 with counter == `DEBOUNCE_COUNT`-1 → PRESSED.
  - PRESSED: `sync`=0 → RELEASE_WAIT.
  - RELEASE_WAIT: `sync`=1 → PRESSED, with no new `press_pulse`. `sync`=0 with counter == `DEBOUNCE_COUNT`-1 → IDLE.
  - Illegal state → IDLE.
- Outputs are Moore-style and registered:
  - `btn_level` = 1 in PRESSED and RELEASE_WAIT.
  - `press_pulse` = 1 only on the cycle following the PRESS_WAIT→PRESSED edge.
  - `release_pulse` = 1 only on the cycle following the RELEASE_WAIT→IDLE edge.
- A bounce shorter than `DEBOUNCE_COUNT` cycles produces no pulse and no level change in either direction.
- Reset mid-operation, on any cycle: state IDLE, both counters 0, all outputs 0 on the next edge. No pulse is emitted for a press that was in progress.

## Timing
- Reset values: `btn_level`, `press_pulse`, `release_pulse`, `long_press` all 0.
- Press latency: raw `btn` goes low and stays low. `press_pulse` and `btn_level` rise exactly `SYNC_STAGES` + `DEBOUNCE_COUNT` + 1 rising edges after the first edge that samples `btn` low.
- Release latency: the same figure, measured from the first edge that samples `btn` high. `release_pulse` rises and `btn_level` falls on that edge.
- Minimum spacing between consecutive `press_pulse` strobes: 2·(`DEBOUNCE_COUNT` + 1) cycles.
- `press_pulse` and `release_pulse` are never high on the same cycle.

## Configuration
- Macro: `BUTTON_LONG_PRESS_EN`.
- Defined:
  - A hold counter of width `$clog2(LONG_PRESS_COUNT)` clears on entry to PRESSED from PRESS_WAIT.
  - It increments in PRESSED, holds in RELEASE_WAIT, and saturates at `LONG_PRESS_COUNT`-1.
  - `long_press` strobes for one cycle when the counter reaches `LONG_PRESS_COUNT`-1. It fires at most once per accepted press.
- Not defined: the `long_press` port, the hold counter and `LONG_PRESS_COUNT` are absent. All other behaviour is identical.

## Structure
- Shared package `button_pkg`:
  - State enum: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - Default constants `DEBOUNCE_COUNT_12MHZ` and `LONG_PRESS_COUNT_12MHZ`.
- One sub-module, `bit_synchronizer`:
  - Parameter `STAGES`.
  - Synchronous active-low reset to 0.
  - Reused for any other asynchronous pin in the design.

## Test plan
Benches run with `DEBOUNCE_COUNT`=4, `LONG_PRESS_COUNT`=20, `SYNC_STAGES`=2.
- Clean press: `btn` goes low and holds → `press_pulse` high for exactly 1 cycle, 7 edges after the first low sample; `btn_level`=1 from then on.
- Bounce: `btn` toggles low/high every 2 cycles for 12 cycles, then holds high → no pulses, `btn_level` stays 0.
- Release with bounce: from PRESSED, `btn` goes high for 3 cycles, low for 2, then high steady → no `release_pulse` during the bounce; `release_pulse` fires 7 edges after the final rise, and no second `press_pulse` occurs.
- Long press (macro defined): hold `btn` low for 40 cycles after `press_pulse` → exactly one `long_press`, 19 cycles after `press_pulse`.
- Long press (macro undefined): same stimulus → no `long_press` port, and the `press_pulse`/`release_pulse` timing matches the defined build.
- Reset mid-press: assert `rst_btn`=0 for 1 cycle while in PRESS_WAIT, then keep `btn` low → outputs 0 after that edge; `press_pulse` arrives 7 edges after reset deasserts.
